// File: rtl/freqdiv_pkg.sv
// Shared constants and state encoding for the clock-division / frequency-measurement blocks.
package freqdiv_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 8_000_000;
    // Gate length giving a 1 s window at the default clock, so counts read directly in Hz.
    localparam int unsigned GATE_CYCLES_1S = CLK_HZ_DEFAULT;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts Sig_In rising edges over back-to-back windows of GATE_CYCLES
// clocks and publishes each completed window's count with a one-cycle valid strobe.
module freq_meter
    import freqdiv_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned GATE_W      = 23,
    parameter int unsigned CNT_W       = 24
) (
    input  logic             Clk_8MHz,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Sig_In,
    output logic [CNT_W-1:0] Freq_Count,
    output logic             Freq_Valid,
    output logic             Overflow,
    output logic             Busy
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    meter_state_e     state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_count_q, freq_count_d;
    logic              freq_valid_q, freq_valid_d;
    logic              overflow_q, overflow_d;

    logic              edge_c;
    logic              last_c;
    logic              sat_now_c;
    logic [CNT_W:0]    sum_c;
    logic [CNT_W-1:0]  cnt_next_c;

    sync_edge_det u_sync (
        .clk      (Clk_8MHz),
        .rst      (Reset),
        .async_in (Sig_In),
        .rise_c   (edge_c)
    );

    // Saturating edge accumulation; the carry out marks a window that overflowed.
    always_comb begin
        sum_c      = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_c};
        sat_now_c  = sat_q | sum_c[CNT_W];
        cnt_next_c = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
        last_c     = (state_q == MEASURE) && (gate_q == GATE_LAST);
    end

    always_ff @(posedge Clk_8MHz or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final window cycle always reports, so Enable alone decides where we go next.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Enable)  state_d = MEASURE;
            MEASURE: if (!Enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gate_d       = '0;
        edge_cnt_d   = '0;
        sat_d        = 1'b0;
        freq_count_d = freq_count_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;
        if (state_q == MEASURE) begin
            if (last_c) begin
                freq_count_d = cnt_next_c;
                overflow_d   = sat_now_c;
                freq_valid_d = 1'b1;
            end else if (Enable) begin
                gate_d     = gate_q + GATE_W'(1);
                edge_cnt_d = cnt_next_c;
                sat_d      = sat_now_c;
            end
        end
    end

    always_ff @(posedge Clk_8MHz or posedge Reset) begin
        if (Reset) begin
            gate_q       <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            gate_q       <= gate_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_count_q <= freq_count_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign Freq_Count = freq_count_q;
    assign Freq_Valid = freq_valid_q;
    assign Overflow   = overflow_q;
    assign Busy       = (state_q == MEASURE);

endmodule
